// File: rtl/inst_queue_pkg.sv
// Shared core definitions for the front end: default word width, reset PC and
// the layout of a queued {pc, inst} entry used by ifetch, the queue and decode.
package inst_queue_pkg;

  localparam int unsigned CoreXlen = 32;
  localparam logic [CoreXlen-1:0] ResetPc = 32'h0000_0000;

  // Packed entry for the default width; pc occupies the upper half
  typedef struct packed {
    logic [CoreXlen-1:0] pc;
    logic [CoreXlen-1:0] inst;
  } iq_entry_t;

  localparam int unsigned EntryWDefault = $bits(iq_entry_t);

  function automatic int unsigned entry_width(input int unsigned xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; storage is cleared only by reset.
// Read data is presented combinationally from the head entry.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A push while full is refused even if a pop happens in the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a sync_fifo of {pc, inst} entries plus the
// valid/ready handshake and branch/flush kill logic.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = CoreXlen
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [XLEN-1:0]          if_pc,
  input  logic [XLEN-1:0]          if_inst,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_inst,
  input  logic                     id_ready,
  input  logic                     branch,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned EntryW = entry_width(XLEN);

  logic              kill;
  logic              push, pop;
  logic              full, empty;
  logic [EntryW-1:0] head_entry;

  assign kill = branch | flush;

  // if_ready depends only on stored occupancy, never on id_ready
  assign if_ready = rst_n & ~kill & ~full;
  assign id_valid = ~kill & ~empty;

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;

  assign id_pc   = head_entry[EntryW-1:XLEN];
  assign id_inst = head_entry[XLEN-1:0];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (kill),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({if_pc, if_inst}),
    .rdata_o (head_entry),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, width of PC and instruction words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port if_valid  input  1  fetch stage presents an instruction.
REQ-006 SHALL have port if_pc  input  XLEN  PC of the presented instruction.
REQ-007 SHALL have port if_inst  input  XLEN  presented instruction word.
REQ-008 SHALL have port if_ready  output  1  queue accepts a push this cycle.
REQ-009 SHALL have port id_valid  output  1  head entry is valid for decode.
REQ-010 SHALL have port id_pc  output  XLEN  PC of the head entry.
REQ-011 SHALL have port id_inst  output  XLEN  instruction word of the head entry.
REQ-012 SHALL have port id_ready  input  1  decode consumes the head this cycle.
REQ-013 SHALL have port branch  input  1  redirect from execute; kills queue contents.
REQ-014 SHALL have port flush  input  1  pipeline flush from exception/commit logic; kills queue contents.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 SHALL define kill = branch | flush.
REQ-017 SHALL push {if_pc, if_inst} at the tail on a rising edge when if_valid & if_ready.
REQ-018 SHALL pop the head on a rising edge when id_valid & id_ready.
REQ-019 SHALL drive if_ready = rst_n & ~kill & (count != DEPTH); no push while full, even if a pop occurs that cycle.
REQ-020 SHALL drive id_valid = ~kill & (count != 0); no same-cycle bypass from if_* to id_*.
REQ-021 SHALL give a pushed entry a latency of exactly one cycle before it can appear at id_*.
REQ-022 SHALL drive id_pc/id_inst combinationally from the head storage entry; they are held stable while id_valid=1 and id_ready=0.
REQ-023 SHALL, on simultaneous push and pop with 0 < count < DEPTH, advance both pointers and leave count unchanged.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL, on an edge with kill=1, set count=0 and both pointers to 0, and discard any push or pop that cycle.
REQ-026 SHALL accept pushes normally on the first cycle after kill deasserts (new-path instruction).
REQ-027 SHALL keep branch and flush with identical effect; simultaneous assertion acts as a single kill.
REQ-028 SHALL preserve order: entries leave in exactly the order they were accepted.

Reset
REQ-029 SHALL, while rst_n=0, force count=0, pointers=0, all storage=0, if_ready=0, id_valid=0, id_pc=0, id_inst=0.
REQ-030 SHALL assert if_ready=1 on the first cycle after rst_n rises, provided kill=0.
REQ-031 SHALL, on reset assertion mid-operation, lose all entries immediately without completing any in-flight push or pop.

Structure
REQ-032 SHALL place XLEN default, the reset PC constant and the {pc, inst} entry width in the shared core package used by ifetch and decode.
REQ-033 SHALL implement storage and pointers as a single sub-module sync_fifo (parameterised DEPTH, WIDTH=2*XLEN, with a clear input); inst_queue adds the kill and handshake logic.
REQ-034 SHALL contain no combinational path from id_ready to if_ready.

Verification
REQ-035 SHALL verify fill: id_ready=0, push PCs 0x0,0x4,0x8,0xC -> count=4, if_ready=0; a fifth push is ignored; drain yields 0x0,0x4,0x8,0xC in order.
REQ-036 SHALL verify streaming: if_valid=1 and id_ready=1 continuously from PC 0x100 -> id_valid one cycle after the first push, then one entry per cycle, count constant at 1.
REQ-037 SHALL verify branch: with 3 entries queued, pulse branch for one cycle with if_valid=1 (PC 0x20) -> count=0, 0x20 never delivered; push PC 0x200 on the next cycle and it is the next id_pc.
REQ-038 SHALL verify flush coinciding with pop and push at count=2 -> count=0, id_valid=0 the next cycle, no entry delivered twice or lost to the new path.
REQ-039 SHALL verify wrap: 10 push/pop cycles of PCs 0x0..0x24 with DEPTH=4 -> all 10 delivered in order, pointers wrap without error.
REQ-040 SHALL verify reset mid-operation: drop rst_n with count=3 -> all outputs 0 immediately; after release if_ready=1, count=0.
